// File: rtl/apb3_pkg.sv
// Shared types and constants for the APB3 requester and its address decoder.
// Build option: define APB_TIMEOUT_EN to bound the ACCESS-phase wait.
package apb3_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int NUM_SLV    = 2;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int TMO_W      = 16;

    // Completer index as found in the top two address bits.
    localparam logic [1:0] SLV1 = 2'b00;
    localparam logic [1:0] SLV2 = 2'b01;

    // Decode table, one 2-bit index per completer, completer 1 in the low slot.
    localparam logic [NUM_SLV*2-1:0] SLV_MAP = {SLV2, SLV1};

endpackage

// File: rtl/apb3_addr_decode.sv
// Combinational completer decode: top two address bits -> one-hot select plus
// an unmapped flag when no completer claims the address.
module apb3_addr_decode
    import apb3_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic [NUM_SLV-1:0] sel,
    output logic               unmapped
);

    logic [1:0] idx;
    logic       unused_addr_bits;

    assign idx = addr[ADDR_W-1:ADDR_W-2];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLV; gi++) begin : g_sel
            assign sel[gi] = (idx == SLV_MAP[gi*2 +: 2]);
        end
    endgenerate

    assign unmapped = ~|sel;

    // Only the region bits matter here; the offset passes straight to paddr.
    assign unused_addr_bits = ^addr[ADDR_W-3:0];

endmodule

// File: rtl/apb3_requester.sv
// APB3 requester: single commands in on valid/ready, SETUP/ACCESS on the bus,
// one-cycle response pulse out. Build option APB_TIMEOUT_EN bounds ACCESS.
module apb3_requester
    import apb3_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    output logic              psel1,
    output logic              psel2,
    output logic              penable,
    input  logic              pready1,
    input  logic              pready2,
    input  logic [DATA_W-1:0] prdata1,
    input  logic [DATA_W-1:0] prdata2,
    input  logic              pslverr1,
    input  logic              pslverr2
);

    apb_state_t         state_reg;
    logic [ADDR_W-1:0]  paddr_reg;
    logic               pwrite_reg;
    logic [DATA_W-1:0]  pwdata_reg;
    logic [NUM_SLV-1:0] psel_reg;
    logic               penable_reg;
    logic               req_ready_reg;
    logic               rsp_valid_reg;
    logic [DATA_W-1:0]  rsp_rdata_reg;
    logic               rsp_err_reg;

    logic [NUM_SLV-1:0] dec_sel;
    logic               dec_unmapped;

    logic               sel_ready;
    logic               sel_slverr;
    logic [DATA_W-1:0]  sel_prdata;

    apb3_addr_decode #(
        .ADDR_W (ADDR_W)
    ) u_decode (
        .addr     (req_addr),
        .sel      (dec_sel),
        .unmapped (dec_unmapped)
    );

    // psel_reg is one-hot, so the completer-2 bit alone picks the return path.
    assign sel_ready  = psel_reg[1] ? pready2  : pready1;
    assign sel_slverr = psel_reg[1] ? pslverr2 : pslverr1;
    assign sel_prdata = psel_reg[1] ? prdata2  : prdata1;

`ifdef APB_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TIMEOUT_LIMIT = TMO_W'(TIMEOUT_CYCLES);
    logic [TMO_W-1:0] tmo_cnt_reg;
    logic             tmo_hit;

    assign tmo_hit = (tmo_cnt_reg == TIMEOUT_LIMIT);
`else
    logic unused_timeout;
    assign unused_timeout = ^(TMO_W'(TIMEOUT_CYCLES));
`endif

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_reg     <= IDLE;
            paddr_reg     <= '0;
            pwrite_reg    <= 1'b0;
            pwdata_reg    <= '0;
            psel_reg      <= '0;
            penable_reg   <= 1'b0;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_reg   <= '0;
`endif
        end else begin
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid && req_ready_reg) begin
                        req_ready_reg <= 1'b0;
                        if (dec_unmapped) begin
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= 1'b1;
                            rsp_rdata_reg <= '0;
                        end else begin
                            paddr_reg  <= req_addr;
                            pwrite_reg <= req_write;
                            pwdata_reg <= req_write ? req_wdata : '0;
                            psel_reg   <= dec_sel;
                            state_reg  <= SETUP;
                        end
                    end else begin
                        // Also covers the response cycle: ready returns one cycle later.
                        req_ready_reg <= 1'b1;
                    end
                end

                SETUP: begin
                    penable_reg <= 1'b1;
                    state_reg   <= ACCESS;
`ifdef APB_TIMEOUT_EN
                    tmo_cnt_reg <= '0;
`endif
                end

                ACCESS: begin
                    if (sel_ready) begin
                        psel_reg      <= '0;
                        penable_reg   <= 1'b0;
                        state_reg     <= IDLE;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= sel_slverr;
                        rsp_rdata_reg <= (!pwrite_reg && !sel_slverr) ? sel_prdata : '0;
`ifdef APB_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        psel_reg      <= '0;
                        penable_reg   <= 1'b0;
                        state_reg     <= IDLE;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= 1'b1;
                        rsp_rdata_reg <= '0;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
`endif
                    end
                end

                default: begin
                    psel_reg    <= '0;
                    penable_reg <= 1'b0;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;
    assign paddr     = paddr_reg;
    assign pwrite    = pwrite_reg;
    assign pwdata    = pwdata_reg;
    assign psel1     = psel_reg[0];
    assign psel2     = psel_reg[1];
    assign penable   = penable_reg;

endmodule

// File: tb/tb_apb3_requester.sv
// Directed self-checking bench for apb3_requester; timeout cases run only
// when APB_TIMEOUT_EN is defined.
module tb_apb3_requester;

    logic        pclk;
    logic        preset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        psel1;
    logic        psel2;
    logic        penable;
    logic        pready1;
    logic        pready2;
    logic [31:0] prdata1;
    logic [31:0] prdata2;
    logic        pslverr1;
    logic        pslverr2;

    int n_assert = 0;
    int n_fail   = 0;
    int lat;

    apb3_requester #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .psel1     (psel1),
        .psel2     (psel2),
        .penable   (penable),
        .pready1   (pready1),
        .pready2   (pready2),
        .prdata1   (prdata1),
        .prdata2   (prdata2),
        .pslverr1  (pslverr1),
        .pslverr2  (pslverr2)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one command for a single edge; req_ready must already be high.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
        req_addr  = 32'h5555_5555;
        req_wdata = 32'h5555_5555;
    endtask

    // Latency counts the acceptance cycle as 1; bounded so a stuck bus cannot hang.
    task automatic wait_rsp(input int max, output int cycles);
        cycles = 1;
        while (!rsp_valid && cycles < max) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        preset    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        pready1   = 1'b0;
        pready2   = 1'b0;
        prdata1   = '0;
        prdata2   = '0;
        pslverr1  = 1'b0;
        pslverr2  = 1'b0;

        tick();
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_psel", {30'd0, psel2, psel1}, 32'd0);
        check("rst_penable", 32'(penable), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_paddr", paddr, 32'd0);
        preset = 1'b0;
        tick();
        check("rst_release_ready", 32'(req_ready), 32'd1);

        // Write to completer 1, zero wait states.
        pready1 = 1'b1;
        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        check("wr_setup_psel1", 32'(psel1), 32'd1);
        check("wr_setup_penable", 32'(penable), 32'd0);
        check("wr_setup_ready", 32'(req_ready), 32'd0);
        check("wr_setup_paddr", paddr, 32'h0000_0010);
        check("wr_setup_pwrite", 32'(pwrite), 32'd1);
        tick();
        check("wr_access_penable", 32'(penable), 32'd1);
        check("wr_access_pwdata", pwdata, 32'hDEAD_BEEF);
        check("wr_access_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        check("wr_rsp_err", 32'(rsp_err), 32'd0);
        check("wr_rsp_rdata", rsp_rdata, 32'd0);
        check("wr_rsp_psel_drop", {30'd0, psel2, psel1, penable}, 32'd0);
        check("wr_rsp_ready", 32'(req_ready), 32'd0);
        $display("txn write addr=00000010 data=deadbeef err=%0d", rsp_err);
        pready1 = 1'b0;
        tick();
        check("wr_pulse_end", 32'(rsp_valid), 32'd0);
        check("wr_ready_back", 32'(req_ready), 32'd1);

        // Read from completer 2 with two wait states; completer 1 signals are noise.
        pready2 = 1'b0;
        prdata2 = 32'h1234_5678;
        pready1 = 1'b1;
        prdata1 = 32'hAAAA_AAAA;
        pslverr1 = 1'b1;
        issue(1'b0, 32'h4000_0020, 32'h0);
        check("rd2_setup_psel", {30'd0, psel2, psel1}, 32'd2);
        check("rd2_setup_pwdata", pwdata, 32'd0);
        tick();
        check("rd2_acc1_penable", 32'(penable), 32'd1);
        tick();
        check("rd2_acc2_hold", {penable, psel2, rsp_valid}, {1'b1, 1'b1, 1'b0});
        check("rd2_acc2_paddr", paddr, 32'h4000_0020);
        tick();
        check("rd2_acc3_hold", {penable, psel2, rsp_valid}, {1'b1, 1'b1, 1'b0});
        check("rd2_acc3_paddr", paddr, 32'h4000_0020);
        pready2 = 1'b1;
        tick();
        check("rd2_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rd2_rsp_rdata", rsp_rdata, 32'h1234_5678);
        check("rd2_rsp_err", 32'(rsp_err), 32'd0);
        $display("txn read addr=40000020 data=%h err=%0d", rsp_rdata, rsp_err);
        pready2 = 1'b0;
        pready1 = 1'b0;
        pslverr1 = 1'b0;
        tick();
        check("rd2_ready_back", 32'(req_ready), 32'd1);

        // Unmapped address: immediate error, no bus activity.
        issue(1'b0, 32'h8000_0000, 32'h0);
        check("unm_bus_idle", {29'd0, psel2, psel1, penable}, 32'd0);
        check("unm_rsp_valid", 32'(rsp_valid), 32'd1);
        check("unm_rsp_err", 32'(rsp_err), 32'd1);
        check("unm_rsp_rdata", rsp_rdata, 32'd0);
        check("unm_ready_low", 32'(req_ready), 32'd0);
        $display("txn read addr=80000000 unmapped err=%0d", rsp_err);
        tick();
        check("unm_pulse_end", 32'(rsp_valid), 32'd0);
        check("unm_err_held", 32'(rsp_err), 32'd1);
        check("unm_ready_back", 32'(req_ready), 32'd1);

        // Read completing with pslverr: data must be suppressed.
        pready1  = 1'b1;
        prdata1  = 32'hFFFF_FFFF;
        pslverr1 = 1'b1;
        issue(1'b0, 32'h0000_0004, 32'h0);
        wait_rsp(12, lat);
        check("slverr_latency", 32'(lat), 32'd3);
        check("slverr_rsp_valid", 32'(rsp_valid), 32'd1);
        check("slverr_rsp_err", 32'(rsp_err), 32'd1);
        check("slverr_rsp_rdata", rsp_rdata, 32'd0);
        $display("txn read addr=00000004 slverr err=%0d data=%h", rsp_err, rsp_rdata);
        pready1  = 1'b0;
        pslverr1 = 1'b0;
        tick();
        check("slverr_ready_back", 32'(req_ready), 32'd1);

        // Reset during ACCESS aborts the transfer without a response.
        issue(1'b1, 32'h0000_0008, 32'h0102_0304);
        tick();
        check("abort_in_access", 32'(penable), 32'd1);
        preset = 1'b1;
        tick();
        check("abort_bus", {29'd0, psel2, psel1, penable}, 32'd0);
        check("abort_paddr", paddr, 32'd0);
        check("abort_pwdata", pwdata, 32'd0);
        check("abort_rsp", {30'd0, rsp_valid, req_ready}, 32'd0);
        preset = 1'b0;
        tick();
        check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        pready2 = 1'b1;
        issue(1'b1, 32'h4000_0004, 32'h0BAD_F00D);
        wait_rsp(12, lat);
        check("post_rst_latency", 32'(lat), 32'd3);
        check("post_rst_err", 32'(rsp_err), 32'd0);
        $display("txn write addr=40000004 data=0badf00d err=%0d lat=%0d", rsp_err, lat);
        pready2 = 1'b0;
        tick();

`ifdef APB_TIMEOUT_EN
        // Limit 4: four counted wait cycles, then the limit cycle terminates.
        issue(1'b0, 32'h0000_0000, 32'h0);
        wait_rsp(20, lat);
        check("tmo_latency", 32'(lat), 32'd7);
        check("tmo_rsp_err", 32'(rsp_err), 32'd1);
        check("tmo_rsp_rdata", rsp_rdata, 32'd0);
        check("tmo_bus_idle", {30'd0, psel1, penable}, 32'd0);
        $display("txn read addr=00000000 timeout err=%0d lat=%0d", rsp_err, lat);
        tick();
        prdata1 = 32'h0000_00C3;
        issue(1'b0, 32'h0000_0000, 32'h0);
        tick();
        tick();
        tick();
        tick();
        pready1 = 1'b1;
        tick();
        check("tmo_late_rsp_valid", 32'(rsp_valid), 32'd1);
        check("tmo_late_rsp_err", 32'(rsp_err), 32'd0);
        check("tmo_late_rsp_rdata", rsp_rdata, 32'h0000_00C3);
        $display("txn read addr=00000000 late-ready err=%0d data=%h", rsp_err, rsp_rdata);
        pready1 = 1'b0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/apb3_requester.md
Name: apb3_requester

Overview:
- APB3 requester: the initiating end of the bus that the team's APB3 completers respond to.
- Accepts single read/write commands on a valid/ready request port and decodes the target completer from the upper address bits.
- Runs the APB3 SETUP/ACCESS sequence, waits on pready, and returns read data and error status as a one-cycle response pulse.
- Sits between the system-side command source and the two APB completers (psel1, psel2).

Parameters:
- ADDR_W, 32, request/paddr address width; bits [ADDR_W-1:ADDR_W-2] select the completer.
- DATA_W, 32, pwdata/prdata/request/response data width.
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit; used only when APB_TIMEOUT_EN is defined; legal range 2..65535.

Ports:
- pclk  in  1  bus clock; all logic on the rising edge.
- preset  in  1  reset, synchronous, active-high.
- req_valid  in  1  command present.
- req_ready  out  1  command accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  completion error: decode, pslverr or timeout.
- paddr  out  ADDR_W  APB address.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_W  APB write data.
- psel1  out  1  completer 1 select.
- psel2  out  1  completer 2 select.
- penable  out  1  ACCESS phase indicator.
- pready1  in  1  completer 1 ready.
- pready2  in  1  completer 2 ready.
- prdata1  in  DATA_W  completer 1 read data.
- prdata2  in  DATA_W  completer 2 read data.
- pslverr1  in  1  completer 1 error; tie 0 if the completer has none.
- pslverr2  in  1  completer 2 error; tie 0 if the completer has none.

Behaviour:
- Reset:
  - All outputs are 0 on the edge where preset is sampled high: paddr, pwrite, pwdata, psel1, psel2, penable, rsp_valid, rsp_rdata, rsp_err, req_ready.
  - State goes to IDLE.
  - req_ready rises on the first edge after preset deasserts.
- Reset mid-transfer aborts immediately: psel/penable drop at that edge and no response is generated.
- States: IDLE, SETUP, ACCESS.
- Address decode on req_addr[ADDR_W-1:ADDR_W-2]:
  - 00 -> completer 1.
  - 01 -> completer 2.
  - 10 and 11 -> unmapped.
- IDLE:
  - req_ready=1; psel1, psel2 and penable are 0.
  - Accept, mapped address: register paddr, pwrite and pwdata (pwdata = req_wdata for writes, 0 for reads); assert the decoded psel; go to SETUP. req_ready=0 from the next cycle.
  - Accept, unmapped address: no bus activity; stay in IDLE. Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0. req_ready stays 0 during that response cycle.
- SETUP: exactly one cycle; psel held, penable=0; go to ACCESS.
- ACCESS:
  - penable=1. paddr, pwrite, pwdata and psel are held stable until completion.
  - Sample the selected completer's pready each cycle; the unselected completer's pready, prdata and pslverr are ignored.
  - On pready=1: psel and penable go to 0 at the next edge, state -> IDLE.
  - At that same edge, rsp_valid=1 for one cycle. rsp_err = selected pslverr. rsp_rdata = selected prdata only if read and no error, else 0.
- Latency:
  - Minimum 3 cycles from acceptance edge to rsp_valid (SETUP, ACCESS, response) with zero wait states.
  - Each wait state adds 1 cycle.
- Throughput: req_ready is 0 during the response cycle and rises 1 cycle after rsp_valid. The next SETUP therefore begins no earlier than 2 cycles after the response.
- Outside IDLE, req_valid is ignored; the request payload need not be held after acceptance.
- rsp_rdata and rsp_err hold their values until the next response. rsp_valid is a strict single-cycle pulse.
- At most one psel is ever high, and never both.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle in which the selected pready=0.
  - When the counter reaches TIMEOUT_CYCLES with pready still 0, the transfer terminates at the next edge: psel and penable go to 0, state -> IDLE.
  - Response: rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - pready=1 in the same cycle as the limit wins and completes normally.
- Not defined: no counter; ACCESS waits on pready indefinitely. TIMEOUT_CYCLES is unused.

Decomposition:
- Package apb3_pkg:
  - State enum typedef: IDLE, SETUP, ACCESS.
  - Completer index constants: SLV1=2'b00, SLV2=2'b01.
  - Default width constants.
- Sub-module apb3_addr_decode (combinational): req_addr -> one-hot select {sel1, sel2} plus unmapped flag; shared with future multi-completer requesters.

Test Plan:
- Write, zero wait: req_addr=32'h0000_0010, wdata=32'hDEAD_BEEF. Expect psel1=1, penable=0 for 1 cycle, then penable=1, pwdata=DEADBEEF; rsp_valid on cycle 3 with rsp_err=0, rsp_rdata=0.
- Read from completer 2 with 2 wait states (pready2 low 2 cycles), prdata2=32'h1234_5678. Expect ACCESS held 3 cycles, stable paddr and psel2, rsp_rdata=12345678, rsp_err=0, 5-cycle latency.
- Unmapped address 32'h8000_0000. Expect no psel/penable activity; rsp_valid=1, rsp_err=1, rsp_rdata=0 one cycle after acceptance; req_ready=0 in the response cycle.
- pslverr1=1 on a read completion with prdata1=32'hFFFF_FFFF. Expect rsp_err=1, rsp_rdata=0.
- preset asserted during ACCESS. Expect all outputs 0 at that edge and no rsp_valid; after release, a new write completes normally.
- APB_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, pready1 held 0. Expect termination after 4 wait cycles with rsp_err=1; a second run with pready1 rising on the 4th cycle completes with rsp_err=0.
